// File: rtl/serial_shift_tx.sv
// Parallel-to-serial transmitter, LSB first; first bit valid one cycle after the load handshake.
// Backpressure: load_ready drops while a word is shifting and while hold freezes the final bit.
module serial_shift_tx #(
  parameter int WIRE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIRE-1:0] data,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            hold,
  output logic            sout,
  output logic            sout_valid,
  output logic            sout_last
);

  localparam int CW = (WIRE > 1) ? $clog2(WIRE) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIRE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIRE-1:0] shreg;
  logic [CW-1:0]   cnt;
  logic            at_last;
  logic            load_fire;

  assign at_last   = (cnt == LAST);
  assign load_fire = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Final bit leaving: chain straight into the next word if one is offered.
        if (!hold && at_last) begin
          state_nxt = load_valid ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;
    sout       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        load_ready = at_last & ~hold;
        sout_valid = 1'b1;
        sout_last  = at_last;
        sout       = shreg[0];
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load_fire) begin
      shreg <= data;
      cnt   <= '0;
    end else if (state == SHIFT && !hold && !at_last) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_shift_tx.sv
// Randomized and directed bench for serial_shift_tx at WIRE=8 and WIRE=1,
// checked against a bit-queue model of the transmit stream.
module tb_serial_shift_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'd0;
  logic       load_valid = 1'b0;
  logic       hold = 1'b0;

  logic rdy8, so8, sv8, sl8;
  logic rdy1, so1, sv1, sl1;

  int checks = 0;
  int failures = 0;

  bit q8[$];
  bit q1[$];
  logic [31:0] obs8, obs1;
  int n8, n1;

  always #5 clk = ~clk;

  serial_shift_tx #(.WIRE(8)) u_w8 (
    .clk(clk), .rst(rst), .data(data), .load_valid(load_valid), .load_ready(rdy8),
    .hold(hold), .sout(so8), .sout_valid(sv8), .sout_last(sl8)
  );

  serial_shift_tx #(.WIRE(1)) u_w1 (
    .clk(clk), .rst(rst), .data(data[0:0]), .load_valid(load_valid), .load_ready(rdy1),
    .hold(hold), .sout(so1), .sout_valid(sv1), .sout_last(sl1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    obs8 = '0;
    obs1 = '0;
    n8 = 0;
    n1 = 0;
  endtask

  // One cycle: drive inputs at negedge, compare against the model, then
  // advance the model to what the following rising edge should do.
  task automatic step(input logic v, input logic [7:0] d, input logic h, input logic r);
    logic e_rdy8, e_rdy1;
    logic [3:0] e8, e1;
    @(negedge clk);
    load_valid = v;
    data = d;
    hold = h;
    rst = r;
    #1;
    if (!r) begin
      q8.delete();
      q1.delete();
    end
    e_rdy8 = (q8.size() == 0) || (q8.size() == 1 && !h);
    e_rdy1 = (q1.size() == 0) || (q1.size() == 1 && !h);
    e8 = {e_rdy8, q8.size() > 0, q8.size() == 1, (q8.size() > 0) ? q8[0] : 1'b0};
    e1 = {e_rdy1, q1.size() > 0, q1.size() == 1, (q1.size() > 0) ? q1[0] : 1'b0};
    chk("w8 rdy/vld/last/sout", {28'd0, rdy8, sv8, sl8, so8}, {28'd0, e8});
    chk("w1 rdy/vld/last/sout", {28'd0, rdy1, sv1, sl1, so1}, {28'd0, e1});
    if (sv8 && n8 < 32) begin
      obs8[n8] = so8;
      n8++;
    end
    if (sv1 && n1 < 32) begin
      obs1[n1] = so1;
      n1++;
    end
    if (r) begin
      if (q8.size() > 0 && !h) q8.delete(0);
      if (q1.size() > 0 && !h) q1.delete(0);
      if (v && e_rdy8) for (int i = 0; i < 8; i++) q8.push_back(d[i]);
      if (v && e_rdy1) q1.push_back(d[0]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    clr();
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("reset outputs", {28'd0, rdy8, sv8, sl8, so8}, 32'h8);
    idle(2);

    // Single word, no hold.
    clr();
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    idle(10);
    chk("a5 bits", {24'd0, obs8[7:0]}, 32'hA5);
    chk("a5 count", n8, 8);

    // Back-to-back words with load_valid held high.
    clr();
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    repeat (8) step(1'b1, 8'h3C, 1'b0, 1'b1);
    idle(10);
    chk("b2b bits", {16'd0, obs8[15:0]}, 32'h3CA5);
    chk("b2b count", n8, 16);

    // Hold for three cycles while bit 2 is on the wire.
    clr();
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    idle(2);
    repeat (3) step(1'b0, 8'd0, 1'b1, 1'b1);
    idle(12);
    chk("hold bits", {21'd0, obs8[10:0]}, 32'h53D);
    chk("hold count", n8, 11);

    // Hold is ignored while idle: the load still goes through.
    clr();
    step(1'b1, 8'hA5, 1'b1, 1'b1);
    idle(10);
    chk("idle hold bits", {24'd0, obs8[7:0]}, 32'hA5);
    chk("idle hold count", n8, 8);

    // load_valid pulses mid-word are ignored.
    clr();
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    idle(10);
    chk("pulse bits", {24'd0, obs8[7:0]}, 32'hA5);
    chk("pulse count", n8, 8);

    // Reset mid-word, outputs clear before any clock edge, then a fresh word.
    clr();
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    repeat (5) step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("async reset", {28'd0, rdy8, sv8, sl8, so8}, 32'h8);
    idle(1);
    clr();
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    idle(10);
    chk("post-reset bits", {24'd0, obs8[7:0]}, 32'hFF);
    chk("post-reset count", n8, 8);

    // WIRE=1 alternating data, one word per cycle.
    clr();
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h01, 1'b0, 1'b1);
    idle(2);
    chk("w1 bits", {29'd0, obs1[2:0]}, 32'h5);
    chk("w1 count", n1, 3);

    // Random traffic with occasional reset.
    repeat (3000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 150) != 0);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_shift_tx.md
SERIAL_SHIFT_TX -- requirements
Module: serial_shift_tx

Interface
REQ-001 SHALL have parameter WIRE, default 1, giving the parallel word width in bits; legal range is 1 or more.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port data, input, WIRE bits: parallel word to transmit.
REQ-005 SHALL have port load_valid, input, 1 bit: data is valid for capture.
REQ-006 SHALL have port load_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 SHALL have port hold, input, 1 bit: freezes shifting while high.
REQ-008 SHALL have port sout, output, 1 bit: serial data out, LSB first.
REQ-009 SHALL have port sout_valid, output, 1 bit: sout carries a valid bit.
REQ-010 SHALL have port sout_last, output, 1 bit: the current bit is bit WIRE-1 of the word.

Function
REQ-011 SHALL implement FSM states IDLE and SHIFT, plus a WIRE-bit shift register shreg and a bit counter cnt of width max(1, clog2(WIRE)).
REQ-012 SHALL transfer a word on any rising clk edge where load_valid and load_ready are both 1 (handshake): shreg <= data, cnt <= 0, state <= SHIFT.
REQ-013 SHALL drive load_ready = 1 in IDLE, and in SHIFT only when cnt == WIRE-1 and hold == 0; otherwise 0.
REQ-014 SHALL drive these outputs combinationally from registered state:
- sout_valid = (state == SHIFT)
- sout = shreg[0] when in SHIFT, else 0
- sout_last = (state == SHIFT) and (cnt == WIRE-1)
REQ-015 SHALL, in SHIFT with hold == 0 and cnt < WIRE-1, on each edge shift shreg right by one (shreg[WIRE-1] <= 0) and increment cnt.
REQ-016 SHALL, in SHIFT with hold == 1, keep shreg, cnt and state unchanged; sout, sout_valid and sout_last stay stable.
REQ-017 SHALL, in SHIFT with cnt == WIRE-1 and hold == 0:
- load the new word and stay in SHIFT with cnt = 0 if load_valid == 1 (back-to-back, no idle bit);
- otherwise go to IDLE.
REQ-018 SHALL present exactly WIRE consecutive unheld cycles of sout_valid per accepted word; latency from the handshake edge to the first bit valid is 1 cycle.
REQ-019 SHALL ignore data and load_valid whenever load_ready == 0.
REQ-020 SHALL, when WIRE == 1, assert sout_last on every valid bit and accept a word every unheld cycle.
REQ-021 SHALL ignore hold in IDLE.

Reset
REQ-022 SHALL, while rst == 0, asynchronously force state = IDLE, shreg = 0 and cnt = 0, giving sout = 0, sout_valid = 0, sout_last = 0 and load_ready = 1.
REQ-023 SHALL abort any word in progress on reset without completing it; the first handshake after rst rises starts a fresh word.

Verification
REQ-024 SHALL cover this scenario: WIRE=8, load 0xA5, hold=0 -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, sout_last only on the 8th, then IDLE with load_ready=1.
REQ-025 SHALL cover this scenario: WIRE=8, words 0xA5 then 0x3C with load_valid held high -> 16 contiguous valid bits (1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0) with no gap.
REQ-026 SHALL cover this scenario: WIRE=8, 0xA5, hold=1 for 3 cycles after bit 2 -> bit 2 (value 1) repeats for 4 cycles, remaining bits unchanged, total 11 valid cycles.
REQ-027 SHALL cover this scenario: WIRE=8, rst pulled low after bit 4 -> all outputs 0 and load_ready=1 immediately, without waiting for clk; after release, loading 0xFF yields eight 1s.
REQ-028 SHALL cover this scenario: WIRE=1, alternating data 1,0,1 with load_valid high -> sout = 1,0,1 with sout_valid=1 and sout_last=1 each cycle.
REQ-029 SHALL cover this scenario: WIRE=8, load_valid pulsed while in SHIFT with cnt < 7 -> the pulse is ignored and the current word completes unchanged.
